demux16_router: RTL and testbench
=================================

Name: demux16_router

Overview:
- 1-to-2 demultiplexer with buffering. A single 16-bit valid/ready input stream is steered by a per-word select to one of two output streams.
- Each output has its own small FIFO, so a stalled consumer on one port does not lose data.
- Sits between the datapath result bus and two downstream consumers, for example the register-file write path and the memory/IO path.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 2, entries per output FIFO. Must be a power of 2 and at least 2.
- CNT_W, 8, width of the per-port delivered-word counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  router can accept the input word this cycle.
- in_data  in  WIDTH  input word.
- in_sel  in  1  destination: 0 routes to port 0, 1 routes to port 1.
- out0_valid  out  1  port 0 FIFO non-empty.
- out0_ready  in  1  port 0 consumer accepts.
- out0_data  out  WIDTH  port 0 head word.
- out1_valid  out  1  port 1 FIFO non-empty.
- out1_ready  in  1  port 1 consumer accepts.
- out1_data  out  WIDTH  port 1 head word.
- out0_count  out  CNT_W  words delivered on port 0; wraps modulo 2^CNT_W.
- out1_count  out  CNT_W  words delivered on port 1; wraps modulo 2^CNT_W.
- last_data  out  WIDTH  copy of the most recently accepted input word.
- last_sel  out  1  in_sel of the most recently accepted input word.

Behaviour:
- Reset (async assert, sync release):
  - Both FIFOs empty (pointers and occupancy cleared).
  - out0_valid and out1_valid = 0; out0_data and out1_data = 0.
  - out0_count and out1_count = 0.
  - last_data = 0; last_sel = 0.
  - in_ready follows its combinational rule from the empty state, so it is 1 during reset.
- in_ready: combinational.
  - in_ready = ~full0 when in_sel = 0.
  - in_ready = ~full1 when in_sel = 1.
  - in_ready depends only on in_sel and FIFO state, never on in_valid or the out*_ready inputs.
- Accept (push):
  - Occurs when in_valid & in_ready at the rising edge.
  - in_data is written to the FIFO selected by in_sel.
  - last_data <= in_data and last_sel <= in_sel on the same edge.
  - last_data and last_sel are unchanged on cycles without an accept.
- Pop: occurs on port k when outk_valid & outk_ready at the rising edge. The head advances and outk_count increments by 1.
- Output data:
  - outk_valid = (occupancy_k != 0).
  - outk_data = FIFO head when valid, otherwise 0.
  - No combinational path from in_data to outk_data.
- Latency:
  - A word accepted at edge N appears on its output at the start of cycle N+1, provided that FIFO was empty.
  - Minimum one-cycle latency.
- Full FIFO with a simultaneous pop: in_ready is still 0; there is no same-cycle pass-through. The slot frees on the following cycle.
- Simultaneous push and pop on the same port, FIFO neither empty nor full: occupancy unchanged, both pointers advance.
- Simultaneous push to one port and pop on the other: fully independent.
- Pointer wrap:
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Full and empty are distinguished by an occupancy counter of log2(DEPTH)+1 bits.
- Ordering: per-port FIFO order is preserved. There is no ordering guarantee between ports.
- Head-of-line blocking: when the selected port is full, the input stalls even if the other port has space. This is intended.
  - Upstream must hold in_data and in_sel stable while in_valid & ~in_ready.
  - Behaviour is undefined if in_sel changes during a stall.
- Counter wrap: count 2^CNT_W - 1 plus one pop gives 0. There is no saturation.
- Reset mid-transfer: all buffered words are discarded immediately, outputs return to reset values, and no pop is counted.
- No X propagation: out*_data must never be X after reset, including from unwritten memory.

Test Plan:
- Single route: rst_n low→high; in_valid=1, in_sel=0, in_data=16'hA5A5 for one cycle, out0_ready=1.
  - Next cycle out0_valid=1, out0_data=A5A5.
  - Following cycle out0_valid=0, out0_count=1.
  - last_data=A5A5, last_sel=0; port 1 untouched.
- Fill and block: out1_ready=0; push 16'h0001, 0002, 0003 with in_sel=1.
  - First two accepted; in_ready=0 on the third.
  - Raise out1_ready: port 1 delivers 0001 then 0002, then 0003 is accepted the cycle after the first pop.
  - out1_count=3 once all have drained.
- Head-of-line: port 0 full (out0_ready=0), present in_sel=0 with 16'h1234 → in_ready=0 and port 1 receives nothing. Switching to a fresh word with in_sel=1 is accepted immediately.
- Steady streaming: alternate in_sel 0/1 with words 0..99, both readys=1.
  - in_ready stays 1 throughout; no loss and no reordering.
  - out0_count=50, out1_count=50.
- Wrap and reset: 256 pops on port 0 → out0_count=0. Then buffer 2 words in port 1, assert rst_n=0 mid-cycle.
  - Outputs return to reset values immediately (async).
  - After release, out1_valid=0 and out1_count=0.
- Random stress: 10k cycles with random in_valid, in_sel and readys, checked against a scoreboard queue per port. Also check that in_ready=~full of the port selected by in_sel every cycle.

Source files
------------

// File: rtl/demux16_router.sv
// 1-to-2 valid/ready demultiplexer: each input word is steered by in_sel into
// one of two small per-port FIFOs, with per-port delivered-word counters.
module demux16_router #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0] out0_count,
  output logic [CNT_W-1:0] out1_count,
  output logic [WIDTH-1:0] last_data,
  output logic             last_sel
);

  localparam int AW = $clog2(DEPTH);

  logic                       w_accept;
  logic [1:0]                 w_push;
  logic [1:0]                 w_pop;
  logic [1:0]                 w_valid;
  logic [1:0]                 w_full;
  logic [1:0]                 w_out_ready;
  logic [1:0][WIDTH-1:0]      w_head;
  logic [1:0][CNT_W-1:0]      w_count;
  logic [WIDTH-1:0]           r_last_data;
  logic                       r_last_sel;

  // Head-of-line blocking is intentional: only the selected port's space matters.
  assign in_ready    = in_sel ? ~w_full[1] : ~w_full[0];
  assign w_accept    = in_valid & in_ready;
  assign w_push      = {w_accept & in_sel, w_accept & ~in_sel};
  assign w_out_ready = {out1_ready, out0_ready};

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_occ;
    logic [CNT_W-1:0] r_count;

    assign w_valid[p] = (r_occ != '0);
    assign w_full[p]  = (r_occ == (AW+1)'(DEPTH));
    assign w_pop[p]   = w_valid[p] & w_out_ready[p];
    assign w_head[p]  = w_valid[p] ? r_mem[r_rd_ptr] : '0;
    assign w_count[p] = r_count;

    // NOTE: non-blocking assignments keep every register update in this block
    // seeing the pre-edge values, so push and pop in one cycle compose cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_occ    <= '0;
        r_count  <= '0;
      end else begin
        if (w_push[p]) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop[p]) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
          r_count  <= r_count + 1'b1;
        end
        case ({w_push[p], w_pop[p]})
          2'b10:   r_occ <= r_occ + 1'b1;
          2'b01:   r_occ <= r_occ - 1'b1;
          default: r_occ <= r_occ;
        endcase
      end
    end

    // NOTE: storage is deliberately not reset; the head is only driven out when
    // occupancy is non-zero, so unwritten entries can never leak X.
    always_ff @(posedge clk) begin
      if (w_push[p]) r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_data <= '0;
      r_last_sel  <= 1'b0;
    end else if (w_accept) begin
      r_last_data <= in_data;
      r_last_sel  <= in_sel;
    end
  end

  assign out0_valid = w_valid[0];
  assign out1_valid = w_valid[1];
  assign out0_data  = w_head[0];
  assign out1_data  = w_head[1];
  assign out0_count = w_count[0];
  assign out1_count = w_count[1];
  assign last_data  = r_last_data;
  assign last_sel   = r_last_sel;

endmodule

// File: tb/tb_demux16_router.sv
// Scoreboard bench for demux16_router: per-port expected-word queues are fed
// by an input monitor and drained by an output monitor.
module tb_demux16_router;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [CNT_W-1:0] out0_count;
  logic [CNT_W-1:0] out1_count;
  logic [WIDTH-1:0] last_data;
  logic             last_sel;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [CNT_W-1:0] m_cnt0 = '0;
  logic [CNT_W-1:0] m_cnt1 = '0;
  logic [WIDTH-1:0] m_last_d = '0;
  logic             m_last_s = 1'b0;

  demux16_router #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .out0_count(out0_count), .out1_count(out1_count),
    .last_data(last_data), .last_sel(last_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic s, input logic [WIDTH-1:0] d,
                        input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Asserts reset at the current time (asynchronously), checks reset values
  // immediately, then releases away from a clock edge.
  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    q0.delete();
    q1.delete();
    m_cnt0   = '0;
    m_cnt1   = '0;
    m_last_d = '0;
    m_last_s = 1'b0;
    #1;
    check("rst_out0_valid", out0_valid, 0);
    check("rst_out1_valid", out1_valid, 0);
    check("rst_out0_data", out0_data, 0);
    check("rst_out1_data", out1_data, 0);
    check("rst_out0_count", out0_count, 0);
    check("rst_out1_count", out1_count, 0);
    check("rst_last_data", last_data, 0);
    check("rst_last_sel", last_sel, 0);
    in_sel = 1'b1;
    #1 check("rst_in_ready_sel1", in_ready, 1);
    in_sel = 1'b0;
    #1 check("rst_in_ready_sel0", in_ready, 1);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Input monitor: decides acceptance at the negedge, records it at the edge.
  initial begin : in_mon
    logic             acc;
    logic             s;
    logic [WIDTH-1:0] d;
    forever begin
      @(negedge clk);
      acc = 1'b0;
      if (rst_n === 1'b1) begin
        check("in_ready_vs_full", in_ready,
              in_sel ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
        acc = in_valid & in_ready;
      end
      s = in_sel;
      d = in_data;
      @(posedge clk);
      if (acc && rst_n === 1'b1) begin
        if (s) q1.push_back(d);
        else   q0.push_back(d);
        m_last_d = d;
        m_last_s = s;
      end
    end
  end

  // Output monitor: compares heads and counters, retires popped words.
  initial begin : out_mon
    logic f0;
    logic f1;
    forever begin
      @(negedge clk);
      f0 = 1'b0;
      f1 = 1'b0;
      if (rst_n === 1'b1) begin
        check("out0_valid", out0_valid, q0.size() != 0);
        check("out1_valid", out1_valid, q1.size() != 0);
        if (out0_valid && q0.size() != 0) check("out0_data", out0_data, q0[0]);
        if (!out0_valid) check("out0_data_idle", out0_data, 0);
        if (out1_valid && q1.size() != 0) check("out1_data", out1_data, q1[0]);
        if (!out1_valid) check("out1_data_idle", out1_data, 0);
        check("out0_count", out0_count, m_cnt0);
        check("out1_count", out1_count, m_cnt1);
        check("last_data", last_data, m_last_d);
        check("last_sel", last_sel, m_last_s);
        f0 = out0_valid & out0_ready;
        f1 = out1_valid & out1_ready;
      end
      @(posedge clk);
      if (rst_n === 1'b1) begin
        if (f0 && q0.size() != 0) begin void'(q0.pop_front()); m_cnt0++; end
        if (f1 && q1.size() != 0) begin void'(q1.pop_front()); m_cnt1++; end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic stalled;
    int   stalls;
    rst_n = 1'b0;
    set_in(0, 0, '0, 0, 0);
    #3 do_reset();

    // Single route to port 0.
    set_in(1, 0, 16'hA5A5, 1, 0);
    step(1);
    set_in(0, 0, '0, 1, 0);
    @(negedge clk);
    check("route_valid", out0_valid, 1);
    check("route_data", out0_data, 16'hA5A5);
    step(1);
    @(negedge clk);
    check("route_drained", out0_valid, 0);
    check("route_count0", out0_count, 1);
    check("route_last_data", last_data, 16'hA5A5);
    check("route_last_sel", last_sel, 0);
    check("route_port1_idle", out1_valid, 0);
    check("route_count1", out1_count, 0);
    step(1);

    // Fill port 1 and block the third word.
    do_reset();
    set_in(1, 1, 16'h0001, 0, 0); step(1);
    set_in(1, 1, 16'h0002, 0, 0); step(1);
    set_in(1, 1, 16'h0003, 0, 0);
    @(negedge clk);
    check("fill_third_blocked", in_ready, 0);
    check("fill_head", out1_data, 16'h0001);
    step(1);
    set_in(1, 1, 16'h0003, 0, 1);
    @(negedge clk);
    check("fill_still_full", in_ready, 0);
    step(1);
    @(negedge clk);
    check("fill_slot_freed", in_ready, 1);
    check("fill_second", out1_data, 16'h0002);
    step(1);
    set_in(0, 0, '0, 0, 1);
    step(2);
    @(negedge clk);
    check("fill_count1", out1_count, 3);
    check("fill_drained", out1_valid, 0);
    check("fill_last_data", last_data, 16'h0003);
    step(1);

    // Head-of-line blocking on a full port 0.
    do_reset();
    set_in(1, 0, 16'h1111, 0, 0); step(1);
    set_in(1, 0, 16'h2222, 0, 0); step(1);
    set_in(1, 0, 16'h1234, 0, 0);
    @(negedge clk);
    check("hol_blocked", in_ready, 0);
    check("hol_port1_empty", out1_valid, 0);
    step(1);
    set_in(1, 1, 16'h5678, 0, 1);
    @(negedge clk);
    check("hol_other_accepted", in_ready, 1);
    step(1);
    set_in(0, 0, '0, 1, 1);
    step(4);
    @(negedge clk);
    check("hol_count0", out0_count, 2);
    check("hol_count1", out1_count, 1);
    step(1);

    // Steady alternating stream.
    do_reset();
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      set_in(1, i[0], 16'(i), 1, 1);
      @(negedge clk);
      if (!in_ready) stalls++;
      step(1);
    end
    set_in(0, 0, '0, 1, 1);
    step(3);
    @(negedge clk);
    check("stream_stalls", stalls, 0);
    check("stream_count0", out0_count, 50);
    check("stream_count1", out1_count, 50);
    step(1);

    // Counter wrap on port 0, then reset with words buffered on port 1.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      set_in(1, 0, 16'(16'hC000 + i), 1, 0);
      step(1);
    end
    set_in(0, 0, '0, 1, 0);
    step(3);
    @(negedge clk);
    check("wrap_count0", out0_count, 0);
    check("wrap_model_count0", out0_count, m_cnt0);
    step(1);
    set_in(1, 1, 16'hAAAA, 0, 0); step(1);
    set_in(1, 1, 16'hBBBB, 0, 0); step(1);
    set_in(0, 0, '0, 0, 0);
    @(negedge clk);
    check("pre_reset_valid1", out1_valid, 1);
    #2 do_reset();
    @(negedge clk);
    check("post_reset_valid1", out1_valid, 0);
    check("post_reset_count1", out1_count, 0);
    step(1);

    // Random stress with held stimulus during stalls.
    do_reset();
    stalled = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (!stalled) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_sel   = $urandom_range(0, 1) == 1;
        in_data  = 16'($urandom);
      end
      out0_ready = ($urandom_range(0, 2) != 0);
      out1_ready = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      stalled = in_valid & ~in_ready;
      step(1);
    end
    set_in(0, 0, '0, 1, 1);
    for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) step(1);
    check("final_q0_empty", q0.size(), 0);
    check("final_q1_empty", q1.size(), 0);
    @(negedge clk);
    check("final_valid0", out0_valid, 0);
    check("final_valid1", out1_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
